// File: rtl/pu_or1k_wb_sram.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | pu_or1k_wb_sram : Wishbone B3 registered-feedback SRAM slave (classic and  |
// |                   linear/wrap bursts). Option macro: PU_OR1K_WB_SRAM_ERR_EN |
// | Revision        : 1.0                                                      |
// +----------------------------------------------------------------------------+
module pu_or1k_wb_sram #(
  parameter int unsigned   AW             = 32,
  parameter int unsigned   DW             = 32,
  parameter logic [AW-1:0] BASE_ADDR      = 32'h0000_0000,
  parameter int unsigned   MEM_SIZE_BYTES = 32768,
  parameter string         MEM_FILE       = ""
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [AW-1:0]   wb_adr_i,
  input  logic [DW-1:0]   wb_dat_i,
  input  logic [DW/8-1:0] wb_sel_i,
  input  logic            wb_we_i,
  input  logic            wb_cyc_i,
  input  logic            wb_stb_i,
  input  logic [2:0]      wb_cti_i,
  input  logic [1:0]      wb_bte_i,
  output logic [DW-1:0]   wb_dat_o,
  output logic            wb_ack_o,
  output logic            wb_err_o,
  output logic            wb_rty_o
);

  localparam int unsigned c_depth = MEM_SIZE_BYTES / 4;
  localparam int unsigned c_ow    = $clog2(c_depth);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BEAT = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            ack_q, ack_d;
  logic            err_q, err_d;
  logic [DW-1:0]   dat_q, dat_d;
  logic [DW-1:0]   mem [c_depth];

  logic            req;
  logic            burst_more;
  logic            mem_we;
  logic [AW-1:0]   wrap_mask;
  logic [AW-1:0]   nxt_adr;
  logic [AW-1:0]   cur_rel, nxt_rel;
  logic [c_ow-1:0] cur_off, nxt_off;
  logic            cur_ok, nxt_ok;
  logic            unused_ok;

  assign req        = wb_cyc_i & wb_stb_i;
  assign burst_more = (wb_cti_i == 3'b010);

  // Wrapped bursts take the masked address bits from a+4 and hold the rest.
  always_comb begin
    case (wb_bte_i)
      2'b01:   wrap_mask = AW'(32'h0000_000C);
      2'b10:   wrap_mask = AW'(32'h0000_001C);
      2'b11:   wrap_mask = AW'(32'h0000_003C);
      default: wrap_mask = '1;
    endcase
  end

  assign nxt_adr = (wb_adr_i & ~wrap_mask) | ((wb_adr_i + AW'(4)) & wrap_mask);
  assign cur_rel = wb_adr_i - BASE_ADDR;
  assign nxt_rel = nxt_adr - BASE_ADDR;
  assign cur_off = cur_rel[c_ow+1:2];
  assign nxt_off = nxt_rel[c_ow+1:2];

`ifdef PU_OR1K_WB_SRAM_ERR_EN
  assign cur_ok = (cur_rel < AW'(MEM_SIZE_BYTES));
  assign nxt_ok = (nxt_rel < AW'(MEM_SIZE_BYTES));
`else
  assign cur_ok = 1'b1;
  assign nxt_ok = 1'b1;
`endif

  assign unused_ok = ^{cur_rel, nxt_rel};

  always_comb begin
    state_d = state_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    dat_d   = dat_q;
    mem_we  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          state_d = ST_BEAT;
          ack_d   = cur_ok;
          err_d   = ~cur_ok;
          if (!wb_we_i && cur_ok) dat_d = mem[cur_off];
        end
      end
      ST_BEAT: begin
        if (!req) begin
          state_d = ST_IDLE;
        end else begin
          mem_we = wb_we_i & ~err_q & cur_ok;
          if (burst_more && !err_q) begin
            state_d = ST_BEAT;
            ack_d   = nxt_ok;
            err_d   = ~nxt_ok;
            if (!wb_we_i && nxt_ok) dat_d = mem[nxt_off];
          end else begin
            state_d = ST_GAP;
          end
        end
      end
      ST_GAP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      dat_q   <= dat_d;
    end
  end

  // Contents survive reset; only the write on the reset edge is suppressed.
  always_ff @(posedge clk_i) begin
    if (mem_we && !rst_i) begin
      for (int i = 0; i < DW/8; i++) begin
        if (wb_sel_i[i]) mem[cur_off][8*i +: 8] <= wb_dat_i[8*i +: 8];
      end
    end
  end

  assign wb_dat_o = dat_q;
  assign wb_ack_o = ack_q;
  assign wb_err_o = err_q;
  assign wb_rty_o = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_pu_or1k_wb_sram.sv
`timescale 1ns/1ps
`default_nettype none
// tb_pu_or1k_wb_sram: randomized Wishbone master checked against a word-array
// memory model; outputs compared every cycle on the falling edge.
module tb_pu_or1k_wb_sram;

  localparam logic [31:0] TB_BASE  = 32'h0000_0000;
  localparam int unsigned TB_SIZE  = 32768;
  localparam int unsigned TB_DEPTH = TB_SIZE / 4;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic [31:0] wb_adr_i = '0;
  logic [31:0] wb_dat_i = '0;
  logic [3:0]  wb_sel_i = '0;
  logic        wb_we_i = 1'b0;
  logic        wb_cyc_i = 1'b0;
  logic        wb_stb_i = 1'b0;
  logic [2:0]  wb_cti_i = '0;
  logic [1:0]  wb_bte_i = '0;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic        wb_err_o;
  logic        wb_rty_o;

  int          vectors = 0;
  int          miscompares = 0;
  logic        chk_en = 1'b0;
  logic        exp_ack = 1'b0;
  logic        exp_err = 1'b0;
  logic [31:0] exp_dat = '0;
  logic [31:0] last_rd = '0;
  logic [31:0] mdl [TB_DEPTH];
  logic [31:0] ack_log [$];
  logic [2:0]  cti_tab [7] = '{3'b000, 3'b001, 3'b011, 3'b100, 3'b101, 3'b110, 3'b111};

  always #5 clk = ~clk;

  pu_or1k_wb_sram #(
    .AW(32), .DW(32), .BASE_ADDR(TB_BASE), .MEM_SIZE_BYTES(TB_SIZE), .MEM_FILE("")
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i), .wb_we_i(wb_we_i),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_cti_i(wb_cti_i), .wb_bte_i(wb_bte_i),
    .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o), .wb_rty_o(wb_rty_o)
  );

  function automatic int widx(input logic [31:0] a);
    return int'(((a - TB_BASE) >> 2) % TB_DEPTH);
  endfunction

  function automatic bit in_rng(input logic [31:0] a);
`ifdef PU_OR1K_WB_SRAM_ERR_EN
    return (a - TB_BASE) < TB_SIZE;
`else
    return (a === a);
`endif
  endfunction

  // Next burst address: +4 for linear, else wrap inside the aligned 16/32/64-byte block.
  function automatic logic [31:0] nxt(input logic [31:0] a, input logic [1:0] bte);
    logic [31:0] blk;
    if (bte == 2'b00) return a + 32'd4;
    blk = 32'd8 << bte;
    return (a / blk) * blk + ((a % blk) + 32'd4) % blk;
  endfunction

  task automatic mwrite(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    for (int i = 0; i < 4; i++) if (s[i]) mdl[widx(a)][8*i +: 8] = d[8*i +: 8];
  endtask

  task automatic pin(input string nm, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      vectors++;
      if (wb_ack_o !== exp_ack) begin
        miscompares++;
        $display("FAIL ack @%0t: got %b, required %b", $time, wb_ack_o, exp_ack);
      end
      if (wb_err_o !== exp_err) begin
        miscompares++;
        $display("FAIL err @%0t: got %b, required %b", $time, wb_err_o, exp_err);
      end
      if (wb_rty_o !== 1'b0) begin
        miscompares++;
        $display("FAIL rty @%0t: got %b, required 0", $time, wb_rty_o);
      end
      if (wb_dat_o !== exp_dat) begin
        miscompares++;
        $display("FAIL dat @%0t: got 0x%08h, required 0x%08h", $time, wb_dat_o, exp_dat);
      end
    end
    if (wb_ack_o === 1'b1) ack_log.push_back(wb_dat_o);
  end

  // Drive one cycle of master signals and state what the outputs must be in it.
  task automatic step(input bit cyc, input bit stb, input bit we, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] s, input logic [2:0] cti,
                      input logic [1:0] bte, input bit eack, input bit eerr);
    @(posedge clk); #1;
    wb_cyc_i = cyc; wb_stb_i = stb; wb_we_i = we; wb_adr_i = a;
    wb_dat_i = d;   wb_sel_i = s;   wb_cti_i = cti; wb_bte_i = bte;
    exp_ack = eack; exp_err = eerr; exp_dat = last_rd;
  endtask

  task automatic idle_step();
    step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'b000, 2'b00, 1'b0, 1'b0);
  endtask

  task automatic classic(input bit we, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic [2:0] cti);
    bit ok;
    ok = in_rng(a);
    step(1'b1, 1'b1, we, a, d, s, cti, 2'b00, 1'b0, 1'b0);
    if (!we && ok) last_rd = mdl[widx(a)];
    step(1'b1, 1'b1, we, a, d, s, cti, 2'b00, ok, !ok);
    if (we && ok) mwrite(a, d, s);
    idle_step();
  endtask

  task automatic burst(input bit we, input logic [31:0] a0, input int n, input logic [1:0] bte,
                       input int pause_at, input int pause_len, input bit rsel);
    logic [31:0] a, d;
    logic [3:0]  s;
    logic [2:0]  cti;
    a = a0;
    d = $urandom;
    s = (we && rsel) ? 4'($urandom_range(0, 15)) : 4'hF;
    step(1'b1, 1'b1, we, a, d, s, 3'b010, bte, 1'b0, 1'b0);
    for (int k = 0; k < n; k++) begin
      cti = (k == n - 1) ? 3'b111 : 3'b010;
      if (!we) last_rd = mdl[widx(a)];
      step(1'b1, 1'b1, we, a, d, s, cti, bte, 1'b1, 1'b0);
      if (we) mwrite(a, d, s);
      a = nxt(a, bte);
      d = $urandom;
      s = (we && rsel) ? 4'($urandom_range(0, 15)) : 4'hF;
      if (k == pause_at && k != n - 1) begin
        if (!we) last_rd = mdl[widx(a)];
        step(1'b1, 1'b0, we, a, d, s, 3'b010, bte, 1'b1, 1'b0);
        for (int p = 1; p < pause_len; p++) step(1'b1, 1'b0, we, a, d, s, 3'b010, bte, 1'b0, 1'b0);
        step(1'b1, 1'b1, we, a, d, s, 3'b010, bte, 1'b0, 1'b0);
      end
    end
    idle_step();
  endtask

  initial begin
    int          kind, n, pat;
    logic [31:0] a;
    logic [1:0]  bte;

    repeat (2) @(posedge clk);
    #1 chk_en = 1'b1;
    idle_step();
    rst_i = 1'b0;

    burst(1'b1, 32'h0, 256, 2'b00, -1, 1, 1'b0);

    classic(1'b1, 32'h100, 32'hDEAD_BEEF, 4'hF, 3'b000);
    classic(1'b0, 32'h100, 32'h0, 4'hF, 3'b000);
    pin("classic_rd_0x100", ack_log[$], 32'hDEAD_BEEF);

    classic(1'b1, 32'h104, 32'hFFFF_FFFF, 4'hF, 3'b000);
    classic(1'b1, 32'h104, 32'h1122_3344, 4'b0101, 3'b000);
    classic(1'b0, 32'h104, 32'h0, 4'hF, 3'b000);
    pin("byte_lane_0x104", ack_log[$], 32'hFF22_FF44);

    classic(1'b1, 32'h108, 32'hCAFE_0108, 4'hF, 3'b000);
    classic(1'b1, 32'h10C, 32'hCAFE_010C, 4'hF, 3'b000);
    ack_log.delete();
    burst(1'b0, 32'h108, 4, 2'b01, -1, 1, 1'b0);
    pin("wrap4_beats", 32'(ack_log.size()), 32'd4);
    pin("wrap4_b0", ack_log[0], 32'hCAFE_0108);
    pin("wrap4_b1", ack_log[1], 32'hCAFE_010C);
    pin("wrap4_b2", ack_log[2], 32'hDEAD_BEEF);
    pin("wrap4_b3", ack_log[3], 32'hFF22_FF44);

    burst(1'b1, 32'h200, 8, 2'b00, 2, 2, 1'b0);
    ack_log.delete();
    burst(1'b0, 32'h200, 8, 2'b00, -1, 1, 1'b0);
    pin("lin8_read_beats", 32'(ack_log.size()), 32'd8);

    // Request raised during GAP is taken from IDLE one cycle later.
    step(1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 4'hF, 3'b000, 2'b00, 1'b0, 1'b0);
    last_rd = mdl[widx(32'h100)];
    step(1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 4'hF, 3'b000, 2'b00, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 32'h104, 32'h0, 4'hF, 3'b000, 2'b00, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 32'h104, 32'h0, 4'hF, 3'b000, 2'b00, 1'b0, 1'b0);
    last_rd = mdl[widx(32'h104)];
    step(1'b1, 1'b1, 1'b0, 32'h104, 32'h0, 4'hF, 3'b000, 2'b00, 1'b1, 1'b0);
    idle_step();

    classic(1'b1, 32'h0000, 32'h5A5A_0000, 4'hF, 3'b000);
    classic(1'b1, 32'h8000, 32'h0A11_A500, 4'hF, 3'b000);
    classic(1'b0, 32'h0000, 32'h0, 4'hF, 3'b000);
`ifdef PU_OR1K_WB_SRAM_ERR_EN
    pin("oob_no_write", ack_log[$], 32'h5A5A_0000);
`else
    pin("oob_alias", ack_log[$], 32'h0A11_A500);
`endif

    for (int i = 0; i < 4; i++) classic(1'b1, 32'h300 + 32'(4 * i), 32'h300 + 32'(4 * i), 4'hF, 3'b000);
    step(1'b1, 1'b1, 1'b1, 32'h300, 32'hB000_0000, 4'hF, 3'b010, 2'b00, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 32'h300, 32'hB000_0000, 4'hF, 3'b010, 2'b00, 1'b1, 1'b0);
    mwrite(32'h300, 32'hB000_0000, 4'hF);
    step(1'b1, 1'b1, 1'b1, 32'h304, 32'hB000_0001, 4'hF, 3'b010, 2'b00, 1'b1, 1'b0);
    rst_i = 1'b1;
    last_rd = 32'h0;
    idle_step();
    rst_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      classic(1'b0, 32'h300 + 32'(4 * i), 32'h0, 4'hF, 3'b000);
      pin("rst_burst_word", ack_log[$], (i == 0) ? 32'hB000_0000 : 32'h300 + 32'(4 * i));
    end

    for (int it = 0; it < 150; it++) begin
      kind = $urandom_range(0, 2);
      if (kind == 0) begin
        a = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
        classic(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
                cti_tab[$urandom_range(0, 6)]);
      end else begin
        bte = 2'($urandom_range(0, 3));
        n   = $urandom_range(1, (bte == 2'b00) ? 8 : 16);
        if (bte == 2'b00) a = {22'd0, 8'($urandom_range(0, 247)), 2'b00};
        else              a = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
        pat = ($urandom_range(0, 2) == 0) ? $urandom_range(0, n - 1) : -1;
        burst(1'($urandom_range(0, 1)), a, n, bte, pat, $urandom_range(1, 3), 1'b1);
      end
    end

    repeat (2) idle_step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
